// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: default geometry shared by the register file, its interface and its read ports
package regfile_mp_pkg;
  localparam int DEF_BW_DATA = 32;
  localparam int DEF_BW_ADDR = 5;
  localparam int DEF_NUM_RD  = 2;
  localparam int DEF_NUM_WR  = 2;
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: packed multi-port read/write bus of the register file
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int BW_DATA = DEF_BW_DATA,
  parameter int BW_ADDR = DEF_BW_ADDR,
  parameter int NUM_RD  = DEF_NUM_RD,
  parameter int NUM_WR  = DEF_NUM_WR
);
  logic [NUM_WR-1:0]         wr_en;
  logic [NUM_WR*BW_ADDR-1:0] wr_addr;
  logic [NUM_WR*BW_DATA-1:0] wr_data;
  logic [NUM_RD*BW_ADDR-1:0] rd_addr;
  logic [NUM_RD*BW_DATA-1:0] rd_data;
  logic                      wr_collision;
  modport master (output wr_en, wr_addr, wr_data, rd_addr, input rd_data, wr_collision);
  modport slave  (input wr_en, wr_addr, wr_data, rd_addr, output rd_data, wr_collision);
endinterface

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport: one combinational read port with write bypass and hardwired-zero entry
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int BW_DATA  = DEF_BW_DATA,
  parameter int BW_ADDR  = DEF_BW_ADDR,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter int DEPTH    = 2**BW_ADDR
) (
  input  logic                             rstn,
  input  logic [DEPTH-1:0][BW_DATA-1:0]    mem,
  input  logic [BW_ADDR-1:0]               rd_addr,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR*BW_ADDR-1:0]        wr_addr,
  input  logic [NUM_WR*BW_DATA-1:0]        wr_data,
  output logic [BW_DATA-1:0]               rd_data
);
  // later ports overwrite earlier ones so the highest enabled index is forwarded
  always_comb begin
    rd_data = mem[rd_addr];
    for (int p = 0; p < NUM_WR; p++)
      if (BYPASS && wr_en[p] && wr_addr[p*BW_ADDR +: BW_ADDR] == rd_addr)
        rd_data = wr_data[p*BW_DATA +: BW_DATA];
    if (!rstn || (ZERO_REG && rd_addr == '0)) rd_data = '0;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with prioritized writes and a registered collision flag
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int BW_DATA  = DEF_BW_DATA,
  parameter int BW_ADDR  = DEF_BW_ADDR,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int NUM_WR   = DEF_NUM_WR,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input logic          i_clk,
  input logic          i_rstn,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2**BW_ADDR;
  logic [DEPTH-1:0][BW_DATA-1:0] mem_q, mem_d;
  logic                          coll_q, coll_d;
  function automatic logic live(input logic [BW_ADDR-1:0] a);
    return !ZERO_REG || a != '0;
  endfunction
  // ascending port order lets the highest-index port win on a shared address
  always_comb begin
    mem_d  = mem_q;
    coll_d = 1'b0;
    for (int p = 0; p < NUM_WR; p++) begin
      if (bus.wr_en[p] && live(bus.wr_addr[p*BW_ADDR +: BW_ADDR]))
        mem_d[bus.wr_addr[p*BW_ADDR +: BW_ADDR]] = bus.wr_data[p*BW_DATA +: BW_DATA];
      for (int q = p + 1; q < NUM_WR; q++)
        if (bus.wr_en[p] && bus.wr_en[q] &&
            bus.wr_addr[p*BW_ADDR +: BW_ADDR] == bus.wr_addr[q*BW_ADDR +: BW_ADDR] &&
            live(bus.wr_addr[p*BW_ADDR +: BW_ADDR]))
          coll_d = 1'b1;
    end
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      mem_q  <= '0;
      coll_q <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      coll_q <= coll_d;
    end
  end
  assign bus.wr_collision = coll_q;
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    regfile_mp_rdport #(
      .BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR), .NUM_WR(NUM_WR),
      .ZERO_REG(ZERO_REG), .BYPASS(BYPASS), .DEPTH(DEPTH)
    ) u_rd (
      .rstn   (i_rstn),
      .mem    (mem_q),
      .rd_addr(bus.rd_addr[r*BW_ADDR +: BW_ADDR]),
      .wr_en  (bus.wr_en),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .rd_data(bus.rd_data[r*BW_DATA +: BW_DATA])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: scoreboard bench for a 2R/2W zero+bypass build and a 4R/1W plain build side by side
module tb_regfile_mp;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_if #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(2), .NUM_WR(2)) bus0 ();
  regfile_mp_if #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(4), .NUM_WR(1)) bus1 ();

  regfile_mp #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(2), .NUM_WR(2), .ZERO_REG(1'b1), .BYPASS(1'b1))
    dut0 (.i_clk(clk), .i_rstn(rstn), .bus(bus0.slave));
  regfile_mp #(.BW_DATA(32), .BW_ADDR(5), .NUM_RD(4), .NUM_WR(1), .ZERO_REG(1'b0), .BYPASS(1'b0))
    dut1 (.i_clk(clk), .i_rstn(rstn), .bus(bus1.slave));

  typedef struct packed {
    logic [1:0][31:0] r0;
    logic [3:0][31:0] r1;
    logic             c0;
    logic             c1;
  } exp_t;
  exp_t q[$];
  exp_t me;

  int checks = 0;
  int errors = 0;

  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  logic        pc0 = 1'b0;
  logic        pc1 = 1'b0;
  logic        cen [2];
  logic [4:0]  ca  [2];
  logic [31:0] cd  [2];

  initial for (int i = 0; i < 32; i++) begin
    m0[i] = '0;
    m1[i] = '0;
  end

  // dut 0: entry 0 hardwired, bypass on; dut 1: single writer, no bypass
  function automatic logic [31:0] rd_ref(input int d, input logic [4:0] a);
    if (d == 0) begin
      if (a == 0) return 32'h0;
      for (int p = 1; p >= 0; p--)
        if (cen[p] && ca[p] == a) return cd[p];
      return m0[a];
    end
    return m1[a];
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, idx, $time, act, exp);
    end
  endtask

  task automatic step(input logic rs, input logic [1:0] en, input logic [4:0] a0, a1,
                      input logic [31:0] d0, d1, input logic [4:0] r0, r1, r2, r3);
    exp_t e;
    logic [4:0] ra [4];
    bit taken [32];
    @(posedge clk);
    #1;
    rstn = rs;
    bus0.wr_en = en; bus0.wr_addr = {a1, a0}; bus0.wr_data = {d1, d0}; bus0.rd_addr = {r1, r0};
    bus1.wr_en = en[0]; bus1.wr_addr = a0; bus1.wr_data = d0; bus1.rd_addr = {r3, r2, r1, r0};
    cen[0] = en[0]; cen[1] = en[1]; ca[0] = a0; ca[1] = a1; cd[0] = d0; cd[1] = d1;
    ra[0] = r0; ra[1] = r1; ra[2] = r2; ra[3] = r3;
    if (!rs) begin
      for (int i = 0; i < 32; i++) begin
        m0[i] = '0;
        m1[i] = '0;
      end
      e = '0;
      pc0 = 1'b0;
      pc1 = 1'b0;
    end else begin
      for (int r = 0; r < 2; r++) e.r0[r] = rd_ref(0, ra[r]);
      for (int r = 0; r < 4; r++) e.r1[r] = rd_ref(1, ra[r]);
      e.c0 = pc0;
      e.c1 = pc1;
      for (int i = 0; i < 32; i++) taken[i] = 1'b0;
      for (int p = 1; p >= 0; p--)
        if (cen[p] && ca[p] != 0 && !taken[ca[p]]) begin
          m0[ca[p]] = cd[p];
          taken[ca[p]] = 1'b1;
        end
      if (cen[0]) m1[ca[0]] = cd[0];
      pc0 = cen[0] && cen[1] && ca[0] == ca[1] && ca[0] != 0;
      pc1 = 1'b0;
    end
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      me = q.pop_front();
      for (int r = 0; r < 2; r++) chk("dut0_rd", r, bus0.rd_data[r*32 +: 32], me.r0[r]);
      for (int r = 0; r < 4; r++) chk("dut1_rd", r, bus1.rd_data[r*32 +: 32], me.r1[r]);
      chk("dut0_coll", 0, {31'h0, bus0.wr_collision}, {31'h0, me.c0});
      chk("dut1_coll", 0, {31'h0, bus1.wr_collision}, {31'h0, me.c1});
    end
  end

  initial begin
    bus0.wr_en = '0; bus0.wr_addr = '0; bus0.wr_data = '0; bus0.rd_addr = '0;
    bus1.wr_en = '0; bus1.wr_addr = '0; bus1.wr_data = '0; bus1.rd_addr = '0;
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b01, 5, 0, 32'hDEADBEEF, 0, 5, 5, 5, 5);
    step(1, 2'b00, 0, 0, 0, 0, 5, 5, 5, 0);
    step(0, 2'b01, 7, 0, 32'h77, 0, 5, 7, 5, 7);
    step(1, 2'b00, 0, 0, 0, 0, 7, 5, 7, 5);
    for (int i = 0; i < 32; i++)
      step(1, 2'b01, 5'(i), 0, 32'(i), 0, 5'(i - 1), 5'(i), 5'(i), 5'(i + 1));
    for (int i = 0; i < 32; i++)
      step(1, 2'b00, 0, 0, 0, 0, 5'(i), 5'(31 - i), 5'(i), 5'(i + 7));
    step(1, 2'b01, 9, 0, 32'h11, 0, 9, 9, 9, 9);
    step(1, 2'b01, 9, 0, 32'h22, 0, 9, 9, 9, 9);
    step(1, 2'b00, 0, 0, 0, 0, 9, 9, 9, 9);
    step(1, 2'b11, 3, 3, 32'hA, 32'hB, 3, 3, 3, 3);
    step(1, 2'b00, 0, 0, 0, 0, 3, 3, 3, 3);
    step(1, 2'b00, 0, 0, 0, 0, 3, 0, 3, 0);
    step(1, 2'b11, 0, 0, 32'h5, 32'h6, 0, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 2'b11, 1, 2, 32'h1, 32'h2, 1, 2, 1, 2);
    step(1, 2'b00, 0, 0, 0, 0, 1, 2, 1, 2);
    step(1, 2'b00, 0, 0, 0, 0, 2, 1, 3, 9);
    for (int n = 0; n < 600; n++) begin
      logic [4:0] a [6];
      for (int k = 0; k < 6; k++)
        a[k] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 5));
      step($urandom_range(0, 49) != 0, 2'($urandom_range(0, 3)), a[0], a[1],
           $urandom, $urandom, a[2], a[3], a[4], a[5]);
    end
    step(1, 2'b00, 0, 0, 0, 0, 0, 1, 2, 3);
    for (int t = 0; t < 10 && q.size() != 0; t++) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected responses never checked", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
